// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-wide chunk per cycle, LSB first.
// Define BITWISE_LOGIC_PARITY_EN to add the data_parity output.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [2:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_zero
`ifdef BITWISE_LOGIC_PARITY_EN
    ,
    output logic             data_parity
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_q;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] f;
    logic             last;

`ifdef BITWISE_LOGIC_PARITY_EN
    logic par_q;
`endif

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < N; s++) begin
            if (cnt == CW'(s)) begin
                a_sl = a_q[s*SLICE +: SLICE];
                b_sl = b_q[s*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        f = '0;
        unique case (op_q)
            3'b000: f = a_sl & b_sl;
            3'b001: f = a_sl | b_sl;
            3'b010: f = a_sl ^ b_sl;
            3'b011: f = ~(a_sl | b_sl);
            3'b100: f = ~(a_sl & b_sl);
            3'b101: f = ~(a_sl ^ b_sl);
            3'b110: f = a_sl & ~b_sl;
            3'b111: f = a_sl;
        endcase
    end

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt   <= '0;
            res_q <= '0;
`ifdef BITWISE_LOGIC_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (ctrl_start) begin
                        a_q   <= data_operandA;
                        b_q   <= data_operandB;
                        op_q  <= ctrl_op;
                        cnt   <= '0;
                        res_q <= '0;
`ifdef BITWISE_LOGIC_PARITY_EN
                        par_q <= 1'b0;
`endif
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    for (int s = 0; s < N; s++) begin
                        if (cnt == CW'(s)) begin
                            res_q[s*SLICE +: SLICE] <= f;
                        end
                    end
`ifdef BITWISE_LOGIC_PARITY_EN
                    par_q <= par_q ^ (^f);
`endif
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state == BUSY);
    assign data_resultRDY = (state == DONE);
    assign data_result    = res_q;
    assign data_zero      = ~|res_q;

`ifdef BITWISE_LOGIC_PARITY_EN
    assign data_parity = par_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit (WIDTH=32, SLICE=8).
// Expected results come from a per-bit truth-table model.
module tb_bitwise_logic_unit;

    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ctrl_start = 1'b0;
    logic [2:0]   ctrl_op = '0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic         busy;
    logic         data_resultRDY;
    logic [W-1:0] data_result;
    logic         data_zero;
`ifdef BITWISE_LOGIC_PARITY_EN
    logic         data_parity;
`endif

    bitwise_logic_unit #(.WIDTH(W), .SLICE(S)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_op        (ctrl_op),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_result    (data_result),
        .data_zero      (data_zero)
`ifdef BITWISE_LOGIC_PARITY_EN
        ,
        .data_parity    (data_parity)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         par;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           mon_en = 0;
    logic [W-1:0] last_res = '0;
    logic         last_par = 1'b0;

    // truth table per op, indexed by {a,b}
    logic [3:0] tts [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0001,
                            4'b0111, 4'b1001, 4'b0100, 4'b1100};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(logic [2:0] op,
                                           logic [W-1:0] a,
                                           logic [W-1:0] b);
        logic [W-1:0] r;
        logic [3:0]   tt;
        tt = tts[op];
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (sbq.size() == 0) begin
                chk("idle_busy", {31'b0, busy}, '0);
                chk("idle_rdy", {31'b0, data_resultRDY}, '0);
                chk("held_result", data_result, last_res);
                chk("held_zero", {31'b0, data_zero}, {31'b0, last_res == '0});
`ifdef BITWISE_LOGIC_PARITY_EN
                chk("held_parity", {31'b0, data_parity}, {31'b0, last_par});
`endif
            end else begin
                exp_t e;
                logic eb;
                e  = sbq[0];
                eb = (cyc >= e.cyc - N) && (cyc < e.cyc);
                chk("busy", {31'b0, busy}, {31'b0, eb});
                if (cyc == e.cyc) begin
                    chk("rdy", {31'b0, data_resultRDY}, 1);
                    chk("result", data_result, e.res);
                    chk("zero", {31'b0, data_zero}, {31'b0, e.res == '0});
`ifdef BITWISE_LOGIC_PARITY_EN
                    chk("parity", {31'b0, data_parity}, {31'b0, e.par});
`endif
                    last_res = e.res;
                    last_par = e.par;
                    void'(sbq.pop_front());
                end else begin
                    chk("rdy_early", {31'b0, data_resultRDY}, '0);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        ctrl_op       = op;
        data_operandA = a;
        data_operandB = b;
        ctrl_start    = 1'b1;
        e.res = model(op, a, b);
        e.par = ^e.res;
        e.cyc = cyc + N + 1;
        sbq.push_back(e);
        tick(1);
        ctrl_start = 1'b0;
    endtask

    task automatic run(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        go(op, a, b);
        tick(N);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sbq.delete();
        last_res = '0;
        last_par = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        do_reset();
        mon_en = 1;
        tick(3);

        run(3'b001, 32'hF0F0_0000, 32'h0F0F_00FF);
        tick(10);

        for (int op = 0; op < 8; op++) begin
            run(3'(op), 32'hAAAA_5555, 32'hFFFF_0000);
            tick(1);
        end

        go(3'b000, 32'h1234_5678, 32'h0);
        tick(1);
        data_operandA = 32'hFFFF_FFFF;
        ctrl_op       = 3'b001;
        ctrl_start    = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        tick(N - 2);
        tick(3);

        run(3'b010, 32'h0F0F_0F0F, 32'h00FF_00FF);
        run(3'b011, 32'h1111_0000, 32'h0000_2222);
        tick(2);

        go(3'b001, 32'hDEAD_BEEF, 32'h0);
        tick(2);
        do_reset();
        tick(6);
        run(3'b111, 32'h0000_0007, 32'hFFFF_FFFF);
        tick(2);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run(op, a, b);
            tick($urandom_range(0, 2));
        end

        tick(5);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
